// File: rtl/dl_loader.sv
// dl_loader: fetches NUM batches of halfwords from DDR as 64-bit-word bursts
// and repacks them into SIZE_buffers-halfword output vectors.
// Optional build macro: DL_LOADER_STRAY_CHECK_EN enables the sticky err flag
// for ddr_en beats that arrive while no burst is outstanding.
module dl_loader #(
  parameter int unsigned NUM                    = 2,
  parameter int unsigned WIDTH_ddr_addr         = 25,
  parameter int unsigned DS_data_NUM_in_1_batch = 224,
  parameter int unsigned SIZE_buffers           = 7,
  parameter int unsigned rdDS_Vaddr_DELTA       = 4032,
  parameter int unsigned WIDTH_BASE_ADDR        = 32,
  parameter logic [WIDTH_BASE_ADDR-1:0] BASE_ADDR = '0,
  parameter int unsigned MAX_WIDTH_Vaddr        = 20
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [15:0]                 ddr_data,
  input  logic                        ddr_en,
  output logic                        ddr_req,
  output logic [WIDTH_ddr_addr-1:0]   ddr_addr,
  output logic [WIDTH_ddr_addr-1:0]   ddr_len,
  output logic                        out_valid,
  output logic [16*SIZE_buffers-1:0]  out_data,
  output logic                        done,
  output logic                        err
);

  localparam int unsigned BEAT_W  = (DS_data_NUM_in_1_batch > 1) ? $clog2(DS_data_NUM_in_1_batch) : 1;
  localparam int unsigned PACK_W  = (SIZE_buffers > 1) ? $clog2(SIZE_buffers) : 1;
  localparam int unsigned BATCH_W = $clog2(NUM + 1);
  localparam int unsigned OUT_W   = 16 * SIZE_buffers;

  localparam logic [BEAT_W-1:0]          BEAT_LAST  = BEAT_W'(DS_data_NUM_in_1_batch - 1);
  localparam logic [PACK_W-1:0]          PACK_LAST  = PACK_W'(SIZE_buffers - 1);
  localparam logic [BATCH_W-1:0]         BATCH_NUM  = BATCH_W'(NUM);
  localparam logic [MAX_WIDTH_Vaddr-1:0] VADDR_STEP = MAX_WIDTH_Vaddr'(rdDS_Vaddr_DELTA);
  localparam logic [WIDTH_ddr_addr-1:0]  BURST_LEN  = WIDTH_ddr_addr'(DS_data_NUM_in_1_batch / 4);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RECV, S_DONE} state_t;

  state_t                      state_q, state_d;
  logic [BEAT_W-1:0]           beat_q, beat_d;
  logic [PACK_W-1:0]           pack_cnt_q, pack_cnt_d;
  logic [OUT_W-1:0]            pack_q, pack_d;
  logic [BATCH_W-1:0]          batch_q, batch_d;
  logic [MAX_WIDTH_Vaddr-1:0]  vaddr_q, vaddr_d;
  logic                        ddr_req_q, ddr_req_d;
  logic [WIDTH_ddr_addr-1:0]   ddr_addr_q, ddr_addr_d;
  logic [WIDTH_ddr_addr-1:0]   ddr_len_q, ddr_len_d;
  logic                        out_valid_q, out_valid_d;
  logic [OUT_W-1:0]            out_data_q, out_data_d;
  logic                        done_q, done_d;

  // Halfword virtual address -> 64-bit-word DDR address, truncated to port width.
  function automatic logic [WIDTH_ddr_addr-1:0] phys_addr(input logic [MAX_WIDTH_Vaddr-1:0] v);
    logic [WIDTH_BASE_ADDR:0] sum;
    sum = {1'b0, BASE_ADDR} + (WIDTH_BASE_ADDR + 1)'(v >> 2);
    return WIDTH_ddr_addr'(sum);
  endfunction

  // State and datapath registers; reset aborts any burst and clears the packer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      beat_q      <= '0;
      pack_cnt_q  <= '0;
      pack_q      <= '0;
      batch_q     <= '0;
      vaddr_q     <= '0;
      ddr_req_q   <= 1'b0;
      ddr_addr_q  <= '0;
      ddr_len_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      pack_cnt_q  <= pack_cnt_d;
      pack_q      <= pack_d;
      batch_q     <= batch_d;
      vaddr_q     <= vaddr_d;
      ddr_req_q   <= ddr_req_d;
      ddr_addr_q  <= ddr_addr_d;
      ddr_len_q   <= ddr_len_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      done_q      <= done_d;
    end
  end

  // Next-state: request issue, beat counting, packing and batch advance.
  // Burst outputs are registered, so the request for the next batch is
  // loaded on the same edge that accepts the previous batch's last beat.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    pack_cnt_d  = pack_cnt_q;
    pack_d      = pack_q;
    batch_d     = batch_q;
    vaddr_d     = vaddr_q;
    ddr_req_d   = ddr_req_q;
    ddr_addr_d  = ddr_addr_q;
    ddr_len_d   = ddr_len_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    done_d      = done_q;

    case (state_q)
      S_IDLE: begin
        state_d    = S_REQ;
        ddr_req_d  = 1'b1;
        ddr_addr_d = phys_addr(vaddr_q);
        ddr_len_d  = BURST_LEN;
      end
      S_REQ, S_RECV: begin
        if (ddr_en) begin
          if (state_q == S_REQ) begin
            state_d   = S_RECV;
            ddr_req_d = 1'b0;
          end
          pack_d = OUT_W'({ddr_data, pack_q} >> 16);
          if (pack_cnt_q == PACK_LAST) begin
            pack_cnt_d  = '0;
            out_valid_d = 1'b1;
            out_data_d  = pack_d;
          end else begin
            pack_cnt_d = pack_cnt_q + 1'b1;
          end
          if (beat_q == BEAT_LAST) begin
            beat_d  = '0;
            vaddr_d = vaddr_q + VADDR_STEP;
            batch_d = batch_q + 1'b1;
            if (batch_d < BATCH_NUM) begin
              state_d    = S_REQ;
              ddr_req_d  = 1'b1;
              ddr_addr_d = phys_addr(vaddr_d);
            end else begin
              state_d   = S_DONE;
              ddr_req_d = 1'b0;
              done_d    = 1'b1;
            end
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        ddr_req_d = 1'b0;
        done_d    = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef DL_LOADER_STRAY_CHECK_EN
  logic err_q;

  // Sticky flag for beats arriving while no burst is outstanding.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if (ddr_en && (state_q == S_IDLE || state_q == S_DONE)) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign ddr_req   = ddr_req_q;
  assign ddr_addr  = ddr_addr_q;
  assign ddr_len   = ddr_len_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign done      = done_q;

endmodule

// File: tb/tb_dl_loader.sv
// Scoreboard bench for dl_loader: expected bursts and output vectors are
// queued by the stimulus process and consumed by independent monitors.
module tb_dl_loader;

  localparam int unsigned S  = 7;
  localparam int unsigned AW = 25;

  logic              clk;
  logic              reset;
  logic [15:0]       ddr_data;
  logic              ddr_en;
  logic              ddr_req;
  logic [AW-1:0]     ddr_addr;
  logic [AW-1:0]     ddr_len;
  logic              out_valid;
  logic [16*S-1:0]   out_data;
  logic              done;
  logic              err;

  int checks   = 0;
  int failures = 0;
  int ov_count = 0;

  logic [16*S-1:0] exp_vec_q[$];
  logic [2*AW-1:0] exp_req_q[$];
  logic            prev_req = 1'b0;

  dl_loader #(
    .NUM(2), .WIDTH_ddr_addr(AW), .DS_data_NUM_in_1_batch(224), .SIZE_buffers(S),
    .rdDS_Vaddr_DELTA(4032), .WIDTH_BASE_ADDR(32), .BASE_ADDR(32'd0), .MAX_WIDTH_Vaddr(20)
  ) dut (
    .clk(clk), .reset(reset), .ddr_data(ddr_data), .ddr_en(ddr_en),
    .ddr_req(ddr_req), .ddr_addr(ddr_addr), .ddr_len(ddr_len),
    .out_valid(out_valid), .out_data(out_data), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Output-vector monitor.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      ov_count++;
      if (exp_vec_q.size() == 0) begin
        check("unexpected_out_valid", 128'(out_valid), 128'(0));
      end else begin
        check("out_data", 128'(out_data), 128'(exp_vec_q.pop_front()));
      end
    end
  end

  // Burst-request monitor: compares address/length on each rising ddr_req.
  always @(negedge clk) begin
    if (ddr_req === 1'b1 && prev_req === 1'b0) begin
      if (exp_req_q.size() == 0) begin
        check("unexpected_ddr_req", 128'(ddr_req), 128'(0));
      end else begin
        logic [2*AW-1:0] r;
        r = exp_req_q.pop_front();
        check("ddr_addr", 128'(ddr_addr), 128'(r[2*AW-1:AW]));
        check("ddr_len", 128'(ddr_len), 128'(r[AW-1:0]));
      end
    end
    prev_req = ddr_req;
  end

  task automatic beat(input logic [15:0] d);
    @(negedge clk);
    ddr_en   = 1'b1;
    ddr_data = d;
    @(posedge clk);
    #1;
    ddr_en = 1'b0;
  endtask

  // Queue the first nvec output vectors of a batch whose beat b carries base+b.
  task automatic push_vectors(input int unsigned base, input int unsigned nvec);
    for (int unsigned k = 0; k < nvec; k++) begin
      logic [16*S-1:0] v;
      for (int unsigned j = 0; j < S; j++) v[16*j +: 16] = 16'(base + S*k + j);
      exp_vec_q.push_back(v);
    end
  endtask

  // Drive nbeats beats with an idle gap every 13th beat.
  task automatic serve(input int unsigned base, input int unsigned nbeats, input bit chk_drop);
    for (int unsigned b = 0; b < nbeats; b++) begin
      if (b % 13 == 12) @(negedge clk);
      beat(16'(base + b));
      if (chk_drop && b == 0) check("ddr_req_drop", 128'(ddr_req), 128'(0));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ddr_req"}, 128'(ddr_req), 128'(0));
    check({tag, "_ddr_addr"}, 128'(ddr_addr), 128'(0));
    check({tag, "_ddr_len"}, 128'(ddr_len), 128'(0));
    check({tag, "_out_valid"}, 128'(out_valid), 128'(0));
    check({tag, "_out_data"}, 128'(out_data), 128'(0));
    check({tag, "_done"}, 128'(done), 128'(0));
    check({tag, "_err"}, 128'(err), 128'(0));
  endtask

  task automatic wait_req(input string tag);
    for (int i = 0; i < 20 && ddr_req !== 1'b1; i++) @(negedge clk);
    check({tag, "_req_seen"}, 128'(ddr_req), 128'(1));
  endtask

  initial begin
    int ov_snap;
    logic exp_err;
    reset    = 1'b0;
    ddr_en   = 1'b0;
    ddr_data = '0;
    #12;
    check_reset_outputs("rst");
    #10;
    exp_req_q.push_back({25'd0, 25'd56});
    reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    check("req_after_release", 128'(ddr_req), 128'(1));
    check("addr_after_release", 128'(ddr_addr), 128'(0));
    check("len_after_release", 128'(ddr_len), 128'(56));

    // Batch 0: halfword b = b; batch 1: halfword b = 0x1000 + b.
    push_vectors(0, 32);
    exp_req_q.push_back({25'd1008, 25'd56});
    serve(0, 224, 1'b1);
    check("batch1_req", 128'(ddr_req), 128'(1));
    check("batch1_addr", 128'(ddr_addr), 128'(1008));
    push_vectors(32'h1000, 32);
    serve(32'h1000, 224, 1'b1);
    repeat (3) @(negedge clk);
    check("done", 128'(done), 128'(1));
    check("req_after_done", 128'(ddr_req), 128'(0));
    check("ov_count_two_batches", 128'(ov_count), 128'(64));
    repeat (10) @(negedge clk);

    // Stray beat after done.
    ov_snap = ov_count;
`ifdef DL_LOADER_STRAY_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    beat(16'hBEEF);
    repeat (3) @(negedge clk);
    check("stray_err", 128'(err), 128'(exp_err));
    check("stray_no_out", 128'(ov_count), 128'(ov_snap));
    check("done_sticky", 128'(done), 128'(1));

    // Restart and abort 100 beats into batch 0.
    #2 reset = 1'b0;
    #3 exp_req_q.push_back({25'd0, 25'd56});
    reset = 1'b1;
    wait_req("restart");
    push_vectors(0, 14);
    serve(0, 100, 1'b0);
    #2 reset = 1'b0;
    #1;
    check_reset_outputs("abort");
    exp_req_q.push_back({25'd0, 25'd56});
    @(negedge clk);
    #2 reset = 1'b1;
    wait_req("after_abort");
    check("after_abort_addr", 128'(ddr_addr), 128'(0));
    repeat (5) @(negedge clk);
    check("vec_queue_empty", 128'(exp_vec_q.size()), 128'(0));
    check("req_queue_empty", 128'(exp_req_q.size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
